// File: rtl/decoder_frame_packer_pkg.sv
// decoder_frame_packer_pkg: shared constants and rate helpers (DECODE_MODE/ENCODE_MODE, TRACEBACK_DEPTH, MAX_CODE_RATE, MIN_CODE_RATE)
package decoder_frame_packer_pkg;
   localparam int TRACEBACK_DEPTH = 16;
   localparam int MAX_CODE_RATE = 3;
   localparam int MIN_CODE_RATE = 2;
   localparam int CNT_W = $clog2(TRACEBACK_DEPTH + 1);
   localparam logic DECODE_MODE = 1'b1;
   localparam logic ENCODE_MODE = 1'b0;
   function automatic logic [MAX_CODE_RATE-1:0] clamp_rate(input logic [MAX_CODE_RATE-1:0] r);
      return (int'(r) < MIN_CODE_RATE) ? MAX_CODE_RATE'(MIN_CODE_RATE) :
             (int'(r) > MAX_CODE_RATE) ? MAX_CODE_RATE'(MAX_CODE_RATE) : r;
   endfunction
   function automatic logic [MAX_CODE_RATE-1:0] sym_mask(input logic [MAX_CODE_RATE-1:0] r);
      logic [MAX_CODE_RATE-1:0] m;
      m = '1;
      return ~(m << r);
   endfunction
   function automatic logic [CNT_W-1:0] frame_bits(input logic [MAX_CODE_RATE-1:0] r);
      return CNT_W'((TRACEBACK_DEPTH / int'(r)) * int'(r));
   endfunction
endpackage

// File: rtl/decoder_frame_packer_frame.sv
// frame_bank: one packer bank (sys_clk, rst active-low sync, i_load/i_clear/i_flush/i_rate/i_sym in; o_data/o_full/o_done out)
module frame_bank
   import decoder_frame_packer_pkg::*;
(
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       i_load,
   input  logic                       i_clear,
   input  logic                       i_flush,
   input  logic [MAX_CODE_RATE-1:0]   i_rate,
   input  logic [MAX_CODE_RATE-1:0]   i_sym,
   output logic [TRACEBACK_DEPTH-1:0] o_data,
   output logic                       o_full,
   output logic                       o_done
);
   logic [TRACEBACK_DEPTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [MAX_CODE_RATE-1:0] rate_q, rate_d, rate;
   logic full_q, full_d, ld;
   always_comb begin
      rate = (cnt_q == '0) ? clamp_rate(i_rate) : rate_q;
      ld = i_load && !full_q;
      data_d = data_q;
      rate_d = rate_q;
      cnt_nxt = cnt_q;
      cnt_d = cnt_q;
      full_d = full_q && !i_clear;
      o_done = 1'b0;
      if (ld) begin
         rate_d = rate;
         data_d = (((cnt_q == '0) ? '0 : data_q) << rate) | TRACEBACK_DEPTH'(i_sym & sym_mask(rate));
         cnt_nxt = cnt_q + CNT_W'(rate);
      end
      if (ld && cnt_nxt == frame_bits(rate)) begin
         full_d = 1'b1;
         cnt_d = '0;
         o_done = 1'b1;
      end else if (i_flush && !full_q && cnt_nxt != '0) begin
         data_d = data_d << (TRACEBACK_DEPTH - int'(cnt_nxt));
         full_d = 1'b1;
         cnt_d = '0;
         o_done = 1'b1;
      end else begin
         cnt_d = cnt_nxt;
      end
   end
   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q <= '0;
         rate_q <= MAX_CODE_RATE'(MIN_CODE_RATE);
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q <= cnt_d;
         rate_q <= rate_d;
         full_q <= full_d;
      end
   end
   assign o_data = data_q;
   assign o_full = full_q;
endmodule

// File: rtl/decoder_frame_packer.sv
// decoder_frame_packer: ping-pong symbol-to-frame packer for the Viterbi path; sys_clk, rst (active-low sync), symbol in (i_mode_sel/i_code_rate/i_sym/i_sym_valid/o_sym_ready), frame out (o_frame/o_frame_valid/i_frame_ready), i_flush active only with FRAME_PACKER_FLUSH_EN
module decoder_frame_packer
   import decoder_frame_packer_pkg::*;
(
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       i_mode_sel,
   input  logic [MAX_CODE_RATE-1:0]   i_code_rate,
   input  logic [MAX_CODE_RATE-1:0]   i_sym,
   input  logic                       i_sym_valid,
   output logic                       o_sym_ready,
   input  logic                       i_flush,
   output logic [TRACEBACK_DEPTH-1:0] o_frame,
   output logic                       o_frame_valid,
   input  logic                       i_frame_ready
);
   logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, accept, drain, flush_req;
   logic [1:0] load, clear, flush, full, done;
   logic [TRACEBACK_DEPTH-1:0] data [2];
`ifdef FRAME_PACKER_FLUSH_EN
   assign flush_req = i_flush;
`else
   logic unused_flush;
   assign unused_flush = i_flush;
   assign flush_req = 1'b0;
`endif
   always_comb begin
      o_sym_ready = (i_mode_sel == DECODE_MODE) && !full[wr_sel_q] && rst;
      accept = i_sym_valid && o_sym_ready;
      drain = full[rd_sel_q] && i_frame_ready;
      load = wr_sel_q ? {accept, 1'b0} : {1'b0, accept};
      flush = wr_sel_q ? {flush_req, 1'b0} : {1'b0, flush_req};
      clear = rd_sel_q ? {drain, 1'b0} : {1'b0, drain};
      wr_sel_d = wr_sel_q ^ (|done);
      rd_sel_d = rd_sel_q ^ drain;
      o_frame = data[rd_sel_q];
      o_frame_valid = full[rd_sel_q];
   end
   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
      end
   end
   for (genvar b = 0; b < 2; b++) begin : g_bank
      frame_bank u_bank (
         .sys_clk (sys_clk),
         .rst     (rst),
         .i_load  (load[b]),
         .i_clear (clear[b]),
         .i_flush (flush[b]),
         .i_rate  (i_code_rate),
         .i_sym   (i_sym),
         .o_data  (data[b]),
         .o_full  (full[b]),
         .o_done  (done[b])
      );
   end
endmodule

// File: doc/decoder_frame_packer.md
Name: decoder_frame_packer

Overview:
- Upstream feeder for the Viterbi decoder path of endec.
- Accepts received code symbols from the channel/demod side, one symbol per handshake; each symbol is i_code_rate bits.
- Packs symbols into TRACEBACK_DEPTH-bit frames that drive i_decoder_data_frame.
- Ping-pong buffered, so symbol intake continues while the decoder consumes the previous frame.

Parameters:
- TRACEBACK_DEPTH, 16, frame width in bits; equals `TRACEBACK_DEPTH.
- MAX_CODE_RATE, 3, maximum bits per symbol; equals `MAX_CODE_RATE.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- i_mode_sel  in  1  `DECODE_MODE enables intake; any other value holds o_sym_ready low.
- i_code_rate  in  MAX_CODE_RATE  bits per symbol; legal range 2..MAX_CODE_RATE.
- i_sym  in  MAX_CODE_RATE  received symbol; valid bits are [i_code_rate-1:0].
- i_sym_valid  in  1  symbol valid.
- o_sym_ready  out  1  packer can accept a symbol.
- i_flush  in  1  close the partial frame (optional feature).
- o_frame  out  TRACEBACK_DEPTH  packed frame, connects to i_decoder_data_frame.
- o_frame_valid  out  1  o_frame holds a complete frame.
- i_frame_ready  in  1  decoder accepts the frame.

Behaviour:
- Reset (rst==0 at a sys_clk edge):
  - Both bank counts = 0, full flags = 0, banks = 0.
  - wr_sel = 0, rd_sel = 0, bank rate latches = 2.
  - Outputs: o_frame = 0, o_frame_valid = 0, o_sym_ready = 0.
  - Reset mid-frame or mid-handshake discards all data. No output is held over.
- Symbol accept: i_sym_valid && o_sym_ready.
- o_sym_ready = (i_mode_sel==`DECODE_MODE) && !full[wr_sel] && rst. It is combinational from registered state.
- Rate latch: i_code_rate is sampled into the bank's rate latch when the first symbol of a frame is accepted (bank count==0). Rate changes mid-frame take effect at the next frame.
- Packing: bank <= (bank << rate) | i_sym[rate-1:0]. The first symbol lands in the highest occupied bits. The count increments by rate.
- Frame complete when count + rate == (TRACEBACK_DEPTH/rate)*rate.
  - Unused MSBs are 0 (e.g. rate 3, depth 16: 5 symbols, bit 15 = 0).
  - On completion: full[wr_sel] <= 1, count <= 0, wr_sel toggles.
- Output side:
  - o_frame = bank[rd_sel]; o_frame_valid = full[rd_sel].
  - On o_frame_valid && i_frame_ready: full[rd_sel] <= 0, rd_sel toggles.
  - o_frame and o_frame_valid stay stable until accepted.
- Latency: the accept that completes a frame in cycle N gives o_frame_valid = 1 in cycle N+1, if that bank is next to read.
- Both banks full: o_sym_ready = 0 until one bank drains. The drain in cycle N raises o_sym_ready in cycle N+1.
- Simultaneous completion and drain in the same cycle on different banks: both take effect, with no stall.
- Out-of-range i_code_rate (<2) is treated as 2.
- Leaving `DECODE_MODE mid-frame: the partial frame is retained and intake resumes on return.

Optional Feature:
- Macro: FRAME_PACKER_FLUSH_EN.
- Defined:
  - i_flush==1 with count[wr_sel]>0 and full[wr_sel]==0 zero-pads the frame: shift left by (TRACEBACK_DEPTH - count).
  - It then marks the bank full and toggles wr_sel in the same cycle.
  - A symbol accepted in the same cycle is packed first, then flushed.
  - A flush with count==0 does nothing.
- Undefined: i_flush is ignored. The port remains for a stable interface.

Decomposition:
- param_def.v (shared):
  - `DECODE_MODE, `ENCODE_MODE.
  - `TRACEBACK_DEPTH, `MAX_CODE_RATE.
  - Minimum code rate constant `MIN_CODE_RATE = 2.
- Sub-module frame_bank, instantiated twice. It holds one shift register, count, rate latch and full flag, with load, clear and flush controls.
- The top level holds wr_sel/rd_sel, the handshake and the output mux.

Test Plan:
- Reset then rate 2, feed 8 symbols 2'b11,01,10,10,10,10,01,10 -> o_frame = 16'b1101101010100110 and o_frame_valid = 1 one cycle after the 8th accept.
- Rate 3, feed 5 symbols 3'b111 -> o_frame = 16'b0111111111111111 after the 5th accept.
- Hold i_frame_ready = 0 and feed 16 rate-2 symbols -> two frames buffered and o_sym_ready = 0. One i_frame_ready pulse -> o_sym_ready = 1 the next cycle, and the second frame appears on o_frame.
- Change i_code_rate 2->3 after 3 symbols -> the current frame completes with 8 rate-2 symbols and the next frame uses rate 3.
- With FRAME_PACKER_FLUSH_EN: 3 rate-2 symbols 2'b10, then i_flush -> o_frame = 16'b1010100000000000, valid the next cycle. Without the macro -> no frame.
- Drive rst low while o_frame_valid = 1 -> next cycle o_frame_valid = 0, o_frame = 0, o_sym_ready = 0.
